// File: rtl/stage_div_if.sv
// Handshake and operand/result bundle between the EX stage and the multi-cycle divider.
interface stage_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic                   signed_div;
    logic [WIDTH-1:0]       opv1;
    logic [WIDTH-1:0]       opv2;
    logic                   start;
    logic                   annul;
    logic [2*WIDTH-1:0]     result;
    logic                   ready;

    modport master (
        output signed_div, opv1, opv2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opv1, opv2, start, annul,
        output result, ready
    );
endinterface

// File: rtl/stage_div.sv
// Restoring DIV/DIVU unit: one quotient bit per cycle, returns {remainder, quotient}
// for the HI/LO write path, holding the result while EX keeps start asserted.
module stage_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    stage_div_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;
    logic               sdiv;
    logic               neg1;
    logic               neg2;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH:0]     trial;
    logic               fits;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // Operand magnitudes for DIV; DIVU passes operands through untouched
    assign mag1 = (bus.signed_div && bus.opv1[WIDTH-1]) ? (~bus.opv1) + WIDTH'(1) : bus.opv1;
    assign mag2 = (bus.signed_div && bus.opv2[WIDTH-1]) ? (~bus.opv2) + WIDTH'(1) : bus.opv2;

    // Partial remainder shifted left with the next dividend bit; one extra bit keeps the carry
    assign trial = {rem, quo[WIDTH-1]};
    assign fits  = trial >= {1'b0, divisor};

    // Quotient negative when signs differ; remainder follows the dividend's sign
    assign q_fix = (sdiv && (neg1 ^ neg2)) ? (~quo) + WIDTH'(1) : quo;
    assign r_fix = (sdiv && neg1)          ? (~rem) + WIDTH'(1) : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            sdiv       <= 1'b0;
            neg1       <= 1'b0;
            neg2       <= 1'b0;
            bus.ready  <= 1'b0;
            bus.result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.ready  <= 1'b0;
                    bus.result <= '0;
                    if (bus.start && !bus.annul) begin
                        sdiv    <= bus.signed_div;
                        neg1    <= bus.signed_div & bus.opv1[WIDTH-1];
                        neg2    <= bus.signed_div & bus.opv2[WIDTH-1];
                        rem     <= '0;
                        quo     <= mag1;
                        divisor <= mag2;
                        cnt     <= '0;
                        state   <= (bus.opv2 == '0) ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    bus.result <= '0;
                    state      <= bus.annul ? S_IDLE : S_END;
                end
                S_ON: begin
                    if (bus.annul) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (cnt == CW'(WIDTH)) begin
                        bus.ready  <= 1'b1;
                        bus.result <= {r_fix, q_fix};
                        state      <= S_END;
                    end else begin
                        rem <= fits ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], fits};
                        cnt <= cnt + CW'(1);
                    end
                end
                S_END: begin
                    // Result stays up until EX drops start; no restart without a low cycle
                    if (bus.annul || !bus.start) begin
                        bus.ready  <= 1'b0;
                        bus.result <= '0;
                        state      <= S_IDLE;
                    end else begin
                        bus.ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_div.sv
// Directed bench for stage_div: table of divisions with hand-computed results, plus
// annul, reset and start-with-annul sequences.
module tb_stage_div;
    logic clk;
    logic rst;

    stage_div_if #(.WIDTH(32)) bus ();

    stage_div #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold start until ready, check latency/result/hold, then release start
    task automatic run_div(input vec_t v);
        int n;
        logic seen;
        logic [31:0] exp_lat;
        exp_lat = (v.b == 32'd0) ? 32'd2 : 32'd33;
        bus.signed_div = v.sd;
        bus.opv1       = v.a;
        bus.opv2       = v.b;
        bus.start      = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (n == 1) begin
                bus.opv1       = ~v.a;
                bus.opv2       = v.b + 32'd3;
                bus.signed_div = ~v.sd;
            end
            if (bus.ready) seen = 1'b1;
        end
        check({v.name, " latency"}, 64'(n - 1), 64'(exp_lat));
        check({v.name, " result"}, bus.result, {v.r, v.q});
        tick();
        tick();
        check({v.name, " hold ready"}, 64'(bus.ready), 64'd1);
        check({v.name, " hold result"}, bus.result, {v.r, v.q});
        bus.start = 1'b0;
        tick();
        check({v.name, " drop ready"}, 64'(bus.ready), 64'd0);
        check({v.name, " drop result"}, bus.result, 64'd0);
        tick();
    endtask

    // Count cycles in which ready shows up over a window
    task automatic watch_quiet(input string name, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.ready) hits++;
        end
        check(name, 64'(hits), 64'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{"u7/2",        1'b0, 32'd7,        32'd2,        32'd3,        32'd1};
        vecs[1]  = '{"s-7/2",       1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2]  = '{"s7/-2",       1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        vecs[3]  = '{"s-7/-2",      1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
        vecs[4]  = '{"s_ovf",       1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        vecs[5]  = '{"u_max/1",     1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
        vecs[6]  = '{"u_8000/ffff", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        vecs[7]  = '{"u_fff9/2",    1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1};
        vecs[8]  = '{"u100/7",      1'b0, 32'd100,      32'd7,        32'd14,       32'd2};
        vecs[9]  = '{"s0/5",        1'b1, 32'd0,        32'd5,        32'd0,        32'd0};
        vecs[10] = '{"u_byzero",    1'b0, 32'd1234,     32'd0,        32'd0,        32'd0};
        vecs[11] = '{"s_byzero",    1'b1, 32'hFFFFFFF0, 32'd0,        32'd0,        32'd0};

        rst = 1'b1;
        bus.signed_div = 1'b0;
        bus.opv1  = '0;
        bus.opv2  = '0;
        bus.start = 1'b0;
        bus.annul = 1'b0;
        tick();
        tick();
        check("reset ready", 64'(bus.ready), 64'd0);
        check("reset result", bus.result, 64'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_div(vecs[i]);

        // start together with annul must not launch a division
        bus.opv1 = 32'd9; bus.opv2 = 32'd4; bus.start = 1'b1; bus.annul = 1'b1;
        watch_quiet("start_with_annul", 40);
        bus.start = 1'b0; bus.annul = 1'b0;
        tick();

        // annul on the 10th iteration edge
        bus.signed_div = 1'b0; bus.opv1 = 32'd50; bus.opv2 = 32'd3; bus.start = 1'b1;
        tick();
        repeat (9) tick();
        bus.annul = 1'b1;
        tick();
        bus.annul = 1'b0; bus.start = 1'b0;
        watch_quiet("annul_no_ready", 40);
        v = vecs[8];
        v.name = "after_annul";
        run_div(v);

        // synchronous reset on the 20th iteration edge
        bus.signed_div = 1'b0; bus.opv1 = 32'd500; bus.opv2 = 32'd3; bus.start = 1'b1;
        tick();
        repeat (19) tick();
        rst = 1'b1;
        tick();
        check("midreset ready", 64'(bus.ready), 64'd0);
        check("midreset result", bus.result, 64'd0);
        rst = 1'b0; bus.start = 1'b0;
        watch_quiet("midreset_no_ready", 20);
        v = '{"after_reset", 1'b0, 32'd500, 32'd3, 32'd166, 32'd2};
        run_div(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
